// File: rtl/pipe_fetch2.sv
// pipe_fetch2: dual-issue fetch stage with one output slot, 1-entry skid and redirect squash.
// Define FETCH_PERF_EN to add the perf_fetch_cnt / perf_kill_cnt counters.
module pipe_fetch2 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallf,
  input  logic [1:0]  pcsrcd,
  input  logic [31:0] pcbranchd,
  input  logic [31:0] pcjumpd,
  input  logic [31:0] pcjrd,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  output logic [31:0] instrf,
  output logic [31:0] instrf2,
  output logic [31:0] pcf,
  output logic [31:0] pcplus4f,
  output logic        validf
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_kill_cnt
`endif
);
  typedef enum logic {S_REQ, S_WAIT} state_t;
  state_t r_state, w_next;
  logic [31:0] r_pc, r_req_pc;
  logic        r_kill, r_sk_v;
  logic [95:0] r_skid;
  logic        w_redir, w_fire, w_rsp, w_acc, w_free, w_load;
  logic [31:0] w_tgt;
  logic [95:0] w_src;
  assign w_redir = (pcsrcd != 2'b00) && !stallf;
  assign w_tgt   = pcsrcd == 2'b01 ? pcbranchd : pcsrcd == 2'b10 ? pcjumpd : pcjrd;
  assign w_fire  = imem_req && imem_gnt;
  assign w_rsp   = (r_state == S_WAIT) && imem_rvalid;
  assign w_acc   = w_rsp && !r_kill && !w_redir;
  assign w_free  = !validf || !stallf;
  assign w_load  = !w_redir && w_free && (r_sk_v || w_acc);
  // pairs are packed {instr2, instr, pc}; the skid always drains ahead of a new response
  assign w_src   = r_sk_v ? r_skid : {imem_rdata, r_req_pc};
  always_ff @(posedge clk)
    if (reset) r_state <= S_REQ;
    else r_state <= w_next;
  always_comb
    w_next = r_state == S_REQ ? (w_fire ? S_WAIT : S_REQ) : (imem_rvalid ? S_REQ : S_WAIT);
  always_comb begin
    imem_req  = (r_state == S_REQ) && !r_sk_v;
    imem_addr = {r_pc[31:2], 2'b00};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
      r_kill   <= 1'b0;
      r_sk_v   <= 1'b0;
      r_skid   <= '0;
      validf   <= 1'b0;
      {instrf2, instrf, pcf} <= '0;
      pcplus4f <= '0;
    end else begin
      r_kill <= w_rsp ? 1'b0 : (w_redir && (w_fire || r_state == S_WAIT)) ? 1'b1 : r_kill;
      r_pc   <= w_redir ? w_tgt : w_fire ? r_pc + 32'd8 : r_pc;
      if (w_fire) r_req_pc <= r_pc;
      if (w_redir || w_free) begin
        validf   <= w_load;
        {instrf2, instrf, pcf} <= w_load ? w_src : '0;
        pcplus4f <= w_load ? w_src[31:0] + 32'd4 : '0;
      end
      if (w_redir) r_sk_v <= 1'b0;
      else if (w_acc && (r_sk_v || !w_free)) begin
        r_sk_v <= 1'b1;
        r_skid <= {imem_rdata, r_req_pc};
      end else if (w_free) r_sk_v <= 1'b0;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk)
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + {31'd0, w_acc};
      perf_kill_cnt  <= perf_kill_cnt + {31'd0, w_rsp && (r_kill || w_redir)};
    end
`endif
endmodule

// File: doc/pipe_fetch2.md
Name: pipe_fetch2

Overview:
Dual-issue instruction fetch stage. It feeds the F->D pipeline register.
- Holds the fetch PC and requests 64-bit instruction pairs from imem over a valid/grant/rvalid handshake.
- Buffers returned pairs: one registered output slot plus a 1-entry skid.
- Applies decode-stage redirects (branch/jump/jr) and squashes stale in-flight responses.
- Presents instrf, instrf2, pcf and pcplus4f to the F->D register; an empty slot is a zero (nop) pair.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (word aligned).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
stallf  in  1  decode not accepting (hazard unit); output slot held
pcsrcd  in  2  redirect select: 00 none, 01 pcbranchd, 10 pcjumpd, 11 pcjrd
pcbranchd  in  32  branch target
pcjumpd  in  32  jump target
pcjrd  in  32  jr register target
imem_req  out  1  request valid
imem_addr  out  32  request address; bits[1:0] always 0
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  64  [31:0]=mem[addr], [63:32]=mem[addr+4]
instrf  out  32  older instruction of the pair
instrf2  out  32  younger instruction of the pair
pcf  out  32  PC of instrf
pcplus4f  out  32  pcf+4
validf  out  1  output slot holds a live pair

Behaviour:
- Reset:
  - pc_q=RESET_PC, state=REQ.
  - validf=0; instrf, instrf2, pcf, pcplus4f all 0.
  - Skid empty; kill=0.
  - Reset mid-transaction drops any outstanding response silently.
- States:
  - REQ: imem_req=1 iff skid empty; imem_addr={pc_q[31:2],2'b00}. On imem_req&imem_gnt: req_pc<=pc_q, pc_q<=pc_q+8, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid go to REQ. At most one request outstanding.
- Response routing (WAIT, rvalid, kill=0). The slot is "free" if !validf, or validf&!stallf.
  - Slot free and skid empty: load slot with instrf=rdata[31:0], instrf2=rdata[63:32], pcf=req_pc, pcplus4f=req_pc+4, validf=1.
  - Otherwise: load skid with the same fields.
- Slot:
  - Consumed on any cycle with validf&!stallf.
  - Refill priority: skid first, then response.
  - Not refilled: validf<=0 and all data outputs <=0.
  - While stallf=1, slot contents are frozen.
- Redirect (pcsrcd!=00 & !stallf):
  - Highest priority after reset. pc_q<=selected target; validf<=0, outputs<=0, skid cleared.
  - In REQ with gnt the same cycle: go to WAIT with kill<=1 (old-PC request squashed).
  - In WAIT without rvalid: kill<=1.
  - In WAIT with rvalid: discard the response, go to REQ.
  - Redirect with stallf=1 is ignored; the hazard unit re-presents it.
- Kill: WAIT with rvalid&kill discards the data, sets kill<=0, goes to REQ. Targets are not re-added to 8.
- Arithmetic: all PC adds are 32-bit modulo; 32'hFFFF_FFF8+8 wraps to 0.
- Latency: single-cycle imem (gnt in REQ, rvalid next cycle) gives validf two cycles after the request; peak throughput is one pair per 2 cycles.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_kill_cnt[31:0].
  - perf_fetch_cnt increments per response accepted into slot or skid.
  - perf_kill_cnt increments per discarded response (kill or redirect-coincident).
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset then 1-cycle imem with gnt=1 and rdata={pc+4,pc} -> imem_addr 0,8,16 on successive REQ cycles; validf with pcf=0/instrf=0, then pcf=8/instrf=8, pcplus4f=pcf+4.
- Hold stallf=1 for 5 cycles with slot full -> slot frozen; the next response lands in skid; imem_req=0 while skid full; on release the skid pair (pcf=0x10) appears before the next fetch at 0x18.
- pcsrcd=01, pcbranchd=0x100 in WAIT with rvalid delayed 3 cycles -> response discarded (validf stays 0); next imem_addr=0x100; perf_kill_cnt=1 if FETCH_PERF_EN.
- pcsrcd=10 coincident with gnt in REQ -> kill set; the old response is dropped; the following request is at pcjumpd.
- pcsrcd=11 with stallf=1 -> no redirect, pc unchanged; same pcsrcd with stallf=0 next cycle -> redirect to pcjrd.
- Redirect to 0xFFFF_FFF8 -> fetch pcf=0xFFFF_FFF8 with pcplus4f=0xFFFF_FFFC; next imem_addr=0x0000_0000.
